// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of ALU, store and branch entries with mispredict flush.
// Macro ROB_BYPASS_EN forwards same-cycle writebacks to the operand lookups.
`ifndef ROB_BIT
`define ROB_BIT 3
`endif

module reorder_buffer #(
    parameter int ROB_SIZE_BIT = `ROB_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    inst_valid,
    input  logic [1:0]              inst_type,
    input  logic [4:0]              inst_rd,
    input  logic                    inst_pred,
    input  logic [31:0]             inst_alt_pc,
    output logic [ROB_SIZE_BIT-1:0] issue_rob_id,
    output logic                    full,
    input  logic                    rs_ready,
    input  logic [ROB_SIZE_BIT-1:0] rs_rob_id,
    input  logic [31:0]             rs_value,
    input  logic                    lsb_ready,
    input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
    input  logic [31:0]             lsb_value,
    input  logic [ROB_SIZE_BIT-1:0] qry1_id,
    input  logic [ROB_SIZE_BIT-1:0] qry2_id,
    output logic                    qry1_ready,
    output logic [31:0]             qry1_value,
    output logic                    qry2_ready,
    output logic [31:0]             qry2_value,
    output logic                    commit_valid,
    output logic [4:0]              commit_rd,
    output logic [31:0]             commit_value,
    output logic [ROB_SIZE_BIT-1:0] commit_rob_id,
    output logic                    commit_store,
    output logic                    clear,
    output logic [31:0]             clear_pc
);

    localparam int N = 1 << ROB_SIZE_BIT;

    typedef enum logic [1:0] {
        T_ALU   = 2'd0,
        T_STORE = 2'd1,
        T_BR    = 2'd2
    } kind_t;

    logic [N-1:0]            busy;
    logic [N-1:0]            done;
    logic [N-1:0]            e_pred;
    logic [1:0]              e_type [N];
    logic [4:0]              e_rd   [N];
    logic [31:0]             e_alt  [N];
    logic [31:0]             e_val  [N];
    logic [ROB_SIZE_BIT-1:0] head;
    logic [ROB_SIZE_BIT-1:0] tail;
    logic [ROB_SIZE_BIT:0]   count;

    logic do_issue;
    logic do_commit;
    logic do_flush;
    logic rs_hit;
    logic lsb_hit;

    assign issue_rob_id = tail;
    assign full         = count == {1'b1, {ROB_SIZE_BIT{1'b0}}};

    assign do_issue  = rdy_in && inst_valid && !full;
    assign do_commit = rdy_in && busy[head] && done[head];
    assign do_flush  = do_commit && e_type[head] == T_BR
                       && e_val[head][0] != e_pred[head];
    assign rs_hit    = rs_ready && busy[rs_rob_id] && !done[rs_rob_id];
    assign lsb_hit   = lsb_ready && busy[lsb_rob_id] && !done[lsb_rob_id];

    // Control state and registered retire outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy          <= '0;
            done          <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_valid  <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            commit_store  <= 1'b0;
            clear         <= 1'b0;
            clear_pc      <= '0;
        end else begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            clear        <= 1'b0;
            if (do_flush) begin
                busy     <= '0;
                done     <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                clear    <= 1'b1;
                clear_pc <= e_alt[head];
            end else if (rdy_in) begin
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    done[head] <= 1'b0;
                    head       <= head + 1'b1;
                    if (e_type[head] == T_STORE) begin
                        commit_store <= 1'b1;
                    end else if (e_type[head] != T_BR) begin
                        commit_valid  <= 1'b1;
                        commit_rd     <= e_rd[head];
                        commit_value  <= e_val[head];
                        commit_rob_id <= head;
                    end
                end
                if (rs_hit) done[rs_rob_id] <= 1'b1;
                if (lsb_hit) done[lsb_rob_id] <= 1'b1;
                if (do_issue) begin
                    busy[tail] <= 1'b1;
                    done[tail] <= inst_type == T_STORE;
                    tail       <= tail + 1'b1;
                end
                unique case ({do_issue, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Entry payload needs no reset: busy/done gate every use of it
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !do_flush) begin
            if (do_issue) begin
                e_type[tail] <= inst_type;
                e_rd[tail]   <= inst_rd;
                e_pred[tail] <= inst_pred;
                e_alt[tail]  <= inst_alt_pc;
                e_val[tail]  <= '0;
            end
            if (rs_hit) e_val[rs_rob_id] <= rs_value;
            if (lsb_hit) e_val[lsb_rob_id] <= lsb_value;
        end
    end

    function automatic logic [32:0] lookup(input logic [ROB_SIZE_BIT-1:0] id);
        logic [32:0] r;
        r = '0;
        if (busy[id] && done[id]) r = {1'b1, e_val[id]};
`ifdef ROB_BYPASS_EN
        else if (busy[id] && rs_ready && rs_rob_id == id) r = {1'b1, rs_value};
        else if (busy[id] && lsb_ready && lsb_rob_id == id) r = {1'b1, lsb_value};
`endif
        return r;
    endfunction

    assign {qry1_ready, qry1_value} = lookup(qry1_id);
    assign {qry2_ready, qry2_value} = lookup(qry2_id);

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed scenarios then randomized traffic
// against a program-order queue model of retirement.
`ifndef ROB_BIT
`define ROB_BIT 3
`endif

module tb_reorder_buffer;

    localparam int RB = `ROB_BIT;
    localparam int SZ = 1 << RB;
`ifdef ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b0;
    logic          inst_valid = 1'b0;
    logic [1:0]    inst_type = '0;
    logic [4:0]    inst_rd = '0;
    logic          inst_pred = 1'b0;
    logic [31:0]   inst_alt_pc = '0;
    logic [RB-1:0] issue_rob_id;
    logic          full;
    logic          rs_ready = 1'b0;
    logic [RB-1:0] rs_rob_id = '0;
    logic [31:0]   rs_value = '0;
    logic          lsb_ready = 1'b0;
    logic [RB-1:0] lsb_rob_id = '0;
    logic [31:0]   lsb_value = '0;
    logic [RB-1:0] qry1_id = '0;
    logic [RB-1:0] qry2_id = '0;
    logic          qry1_ready;
    logic [31:0]   qry1_value;
    logic          qry2_ready;
    logic [31:0]   qry2_value;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value;
    logic [RB-1:0] commit_rob_id;
    logic          commit_store;
    logic          clear;
    logic [31:0]   clear_pc;

    reorder_buffer #(.ROB_SIZE_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .inst_valid(inst_valid), .inst_type(inst_type), .inst_rd(inst_rd),
        .inst_pred(inst_pred), .inst_alt_pc(inst_alt_pc),
        .issue_rob_id(issue_rob_id), .full(full),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .qry1_id(qry1_id), .qry2_id(qry2_id),
        .qry1_ready(qry1_ready), .qry1_value(qry1_value),
        .qry2_ready(qry2_ready), .qry2_value(qry2_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_rob_id(commit_rob_id),
        .commit_store(commit_store), .clear(clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    // Model entry in program order; kind 0 ALU commit, 1 store, 2 clear
    typedef struct {
        int          id;
        int          ty;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] alt;
        logic [31:0] val;
        bit          wr;
    } ent_t;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] val;
        int          id;
        logic [31:0] pc;
    } exp_t;

    ent_t ml[$];
    exp_t expq[$];
    exp_t me;
    int   mtail;
    bit   pending;
    int   total;
    int   bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_issue(input int ty, input logic [4:0] rd, input logic pr,
                               input logic [31:0] alt);
        ent_t e;
        chk("issue_id", 32'(issue_rob_id), 32'(mtail));
        e.id   = mtail;
        e.ty   = ty;
        e.rd   = rd;
        e.pred = pr;
        e.alt  = alt;
        e.val  = '0;
        e.wr   = (ty == 1);
        ml.push_back(e);
        mtail = (mtail + 1) % SZ;
    endtask

    task automatic model_wb(input int id, input logic [31:0] v);
        foreach (ml[i]) begin
            if (ml[i].id == id && !ml[i].wr) begin
                ml[i].val = v;
                ml[i].wr  = 1'b1;
                if (ml[i].ty == 2 && v[0] != ml[i].pred) pending = 1'b1;
            end
        end
    endtask

    // Retirement is strictly in program order once the oldest entry has its result
    task automatic model_advance();
        ent_t e;
        exp_t x;
        while (ml.size() > 0 && ml[0].wr) begin
            e      = ml.pop_front();
            x.kind = e.ty;
            x.rd   = e.rd;
            x.val  = e.val;
            x.id   = e.id;
            x.pc   = e.alt;
            if (e.ty != 2) begin
                expq.push_back(x);
            end else if (e.val[0] != e.pred) begin
                expq.push_back(x);
                ml.delete();
            end
        end
    endtask

    task automatic drive(input bit iv, input int ty, input logic [4:0] rd, input bit pr,
                         input logic [31:0] alt, input bit rv, input int rid,
                         input logic [31:0] rval, input bit lv, input int lid,
                         input logic [31:0] lval, input bit rdy);
        rdy_in     = rdy;
        rs_ready   = rv;
        rs_rob_id  = RB'(rid);
        rs_value   = rval;
        lsb_ready  = lv;
        lsb_rob_id = RB'(lid);
        lsb_value  = lval;
        if (rdy) begin
            if (rv) model_wb(rid, rval);
            if (lv) model_wb(lid, lval);
        end
        if (pending) iv = 1'b0;
        inst_valid  = iv;
        inst_type   = 2'(ty);
        inst_rd     = rd;
        inst_pred   = pr;
        inst_alt_pc = alt;
        if (rdy && iv && !full) model_issue(ty, rd, pr, alt);
        if (rdy) model_advance();
    endtask

    task automatic idle(input bit rdy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic nxt();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        expq.delete();
        ml.delete();
        mtail   = 0;
        pending = 1'b0;
        rst_in  = 1'b1;
        idle(1'b1);
        nxt();
        nxt();
        chk("rst_full", 32'(full), 0);
        chk("rst_issue_id", 32'(issue_rob_id), 0);
        chk("rst_commit_valid", 32'(commit_valid), 0);
        chk("rst_commit_store", 32'(commit_store), 0);
        chk("rst_clear", 32'(clear), 0);
        chk("rst_clear_pc", clear_pc, 0);
        rst_in = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while ((expq.size() > 0 || pending) && n < 50) begin
            idle(1'b1);
            nxt();
            n++;
        end
        chk(nm, 32'(expq.size()), 0);
    endtask

    function automatic logic [31:0] gen_val(input ent_t e);
        logic [31:0] v;
        v = $urandom;
        if (e.ty == 2) v[0] = ($urandom_range(0, 3) == 0) ? ~e.pred : e.pred;
        return v;
    endfunction

    // Monitor: every retire-side pulse must match the oldest expected event
    always @(posedge clk_in) begin
        #1;
        if (!rst_in) begin
            if (commit_valid === 1'b1 || commit_store === 1'b1 || clear === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire actual v=%0b s=%0b c=%0b required none",
                             commit_valid, commit_store, clear);
                end else begin
                    me = expq.pop_front();
                    if (commit_valid === 1'b1) begin
                        chk("commit_kind", 0, 32'(me.kind));
                        chk("commit_rd", 32'(commit_rd), 32'(me.rd));
                        chk("commit_value", commit_value, me.val);
                        chk("commit_rob_id", 32'(commit_rob_id), 32'(me.id));
                    end else if (commit_store === 1'b1) begin
                        chk("store_kind", 1, 32'(me.kind));
                    end else begin
                        chk("clear_kind", 2, 32'(me.kind));
                        chk("clear_pc", clear_pc, me.pc);
                        pending = 1'b0;
                        mtail   = 0;
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        do_reset();

        // Single ALU issue, writeback, commit
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 1);
        nxt();
        wait_empty("alu_commit_drain");

        // Fill, ignored extra issue, head retire, tail wrap
        do_reset();
        for (int i = 0; i < SZ; i++) begin
            drive(1, 0, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0, 0, 1);
            nxt();
        end
        chk("full_set", 32'(full), 1);
        drive(1, 0, 31, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        chk("full_ignore_id", 32'(issue_rob_id), 0);
        chk("full_ignore_full", 32'(full), 1);
        drive(0, 0, 0, 0, 0, 1, 0, 32'hA0, 0, 0, 0, 1);
        nxt();
        chk("full_before_commit", 32'(full), 1);
        idle(1'b1);
        nxt();
        chk("full_after_commit", 32'(full), 0);
        chk("tail_wrap", 32'(issue_rob_id), 0);
        for (int i = 1; i < SZ; i += 2) begin
            drive(0, 0, 0, 0, 0, 1, i, 32'(i * 3), (i + 1 < SZ), i + 1, 32'(i * 5), 1);
            nxt();
        end
        wait_empty("full_drain");

        // Out-of-order writeback, in-order consecutive commits
        do_reset();
        drive(1, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        drive(1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 1, 1, 32'hB1, 0, 0, 0, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hB0, 1);
        nxt();
        chk("ooo_no_commit_yet", 32'(commit_valid), 0);
        idle(1'b1);
        nxt();
        chk("ooo_first_valid", 32'(commit_valid), 1);
        chk("ooo_first_id", 32'(commit_rob_id), 0);
        idle(1'b1);
        nxt();
        chk("ooo_second_valid", 32'(commit_valid), 1);
        chk("ooo_second_id", 32'(commit_rob_id), 1);
        wait_empty("ooo_drain");

        // Mispredicted branch flushes the younger ALU entry
        do_reset();
        drive(1, 2, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        drive(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 1, 1, 32'h55, 0, 0, 0, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 1);
        nxt();
        idle(1'b1);
        nxt();
        chk("flush_clear", 32'(clear), 1);
        chk("flush_pc", clear_pc, 32'h100);
        chk("flush_no_commit", 32'(commit_valid), 0);
        chk("flush_tail", 32'(issue_rob_id), 0);
        chk("flush_not_full", 32'(full), 0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            nxt();
        end
        wait_empty("flush_drain");

        // Lookup of an entry written in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 5'(i + 20), 0, 0, 0, 0, 0, 0, 0, 0, 1);
            nxt();
        end
        qry1_id = 3;
        qry2_id = 2;
        drive(0, 0, 0, 0, 0, 1, 3, 32'hBEEF, 0, 0, 0, 1);
        #1;
        chk("qry_same_ready", 32'(qry1_ready), 32'(BYP));
        chk("qry_same_value", qry1_value, BYP ? 32'hBEEF : 32'h0);
        chk("qry_unwritten_ready", 32'(qry2_ready), 0);
        chk("qry_unwritten_value", qry2_value, 0);
        nxt();
        idle(1'b1);
        #1;
        chk("qry_next_ready", 32'(qry1_ready), 1);
        chk("qry_next_value", qry1_value, 32'hBEEF);
        nxt();
        drive(0, 0, 0, 0, 0, 1, 0, 32'hC0, 1, 1, 32'hC1, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'hC2, 1);
        nxt();
        wait_empty("qry_drain");

        // Stall with a ready head
        do_reset();
        drive(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 1);
        nxt();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            nxt();
            chk("stall_no_commit", 32'(commit_valid), 0);
        end
        idle(1'b1);
        nxt();
        chk("stall_release_valid", 32'(commit_valid), 1);
        chk("stall_release_rd", 32'(commit_rd), 9);
        wait_empty("stall_drain");

        // Reset while a ready entry is about to retire
        drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 1, 1, 32'h99, 0, 0, 0, 1);
        nxt();
        do_reset();
        idle(1'b1);
        nxt();
        chk("midrst_no_commit", 32'(commit_valid), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int          un[$];
            int          ri;
            int          li;
            bit          rv;
            bit          lv;
            int          ty;
            logic [31:0] rval;
            logic [31:0] lval;
            un.delete();
            foreach (ml[i]) if (!ml[i].wr) un.push_back(i);
            rv = 1'b0;
            lv = 1'b0;
            ri = 0;
            li = 0;
            rval = '0;
            lval = '0;
            if (un.size() > 0 && $urandom_range(0, 2) != 0) begin
                ri   = un[$urandom_range(0, un.size() - 1)];
                rv   = 1'b1;
                rval = gen_val(ml[ri]);
            end
            if (un.size() > 1 && $urandom_range(0, 2) == 0) begin
                li = un[$urandom_range(0, un.size() - 1)];
                if (!(rv && li == ri)) begin
                    lv   = 1'b1;
                    lval = gen_val(ml[li]);
                end
            end
            ty = $urandom_range(0, 9);
            ty = (ty < 5) ? 0 : (ty < 8) ? 1 : 2;
            drive($urandom_range(0, 9) < 6, ty, 5'($urandom), 1'($urandom), $urandom,
                  rv, rv ? ml[ri].id : 0, rval, lv, lv ? ml[li].id : 0, lval,
                  $urandom_range(0, 9) != 0);
            nxt();
        end

        for (int c = 0; c < 400 && (ml.size() > 0 || expq.size() > 0 || pending); c++) begin
            int un[$];
            int ri;
            un.delete();
            foreach (ml[i]) if (!ml[i].wr) un.push_back(i);
            if (un.size() > 0) begin
                ri = un[0];
                drive(0, 0, 0, 0, 0, 1, ml[ri].id, gen_val(ml[ri]), 0, 0, 0, 1);
            end else begin
                idle(1'b1);
            end
            nxt();
        end
        chk("random_drain", 32'(expq.size() + ml.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE_BIT, default `ROB_BIT, meaning log2 of entry count; ROB ids are ROB_SIZE_BIT wide.
REQ-002 SHALL have one clock and synchronous active-high reset: clk_in  input  1  system clock (rising edge); rst_in  input  1  synchronous active-high reset.
REQ-003 SHALL have rdy_in  input  1  global ready; low pauses the block.
REQ-004 SHALL have inst_valid  input  1  issue request, and inst_type  input  2  entry kind: 0 ALU write, 1 store, 2 branch.
REQ-005 SHALL have inst_rd  input  5  destination register, and inst_pred  input  1  predicted taken (branch only).
REQ-006 SHALL have inst_alt_pc  input  32  recovery PC (branch only).
REQ-007 SHALL have issue_rob_id  output  ROB_SIZE_BIT  id assigned to the current issue (tail), and full  output  1  no free entry.
REQ-008 SHALL have rs_ready/lsb_ready  input  1, rs_rob_id/lsb_rob_id  input  ROB_SIZE_BIT, and rs_value/lsb_value  input  32  writeback buses.
REQ-009 SHALL have qry1_id/qry2_id  input  ROB_SIZE_BIT  operand lookups, and qry1_ready/qry2_ready  output  1 plus qry1_value/qry2_value  output  32  lookup results.
REQ-010 SHALL have commit_valid  output  1, commit_rd  output  5, commit_value  output  32, commit_rob_id  output  ROB_SIZE_BIT  register commit.
REQ-011 SHALL have commit_store  output  1  store retire pulse to LSB.
REQ-012 SHALL have clear  output  1  mispredict flush pulse, and clear_pc  output  32  redirect PC.

Function
REQ-013 SHALL be a circular buffer: head, tail, and a count of ROB_SIZE_BIT+1 bits; ids and pointers wrap modulo 2^ROB_SIZE_BIT.
REQ-014 SHALL assign issue_rob_id = tail combinationally.
REQ-015 SHALL assert full combinationally when count == 2^ROB_SIZE_BIT; an issue while full is ignored (upstream contract violation, no state change).
REQ-016 SHALL, on an accepted issue edge, write the entry with busy=1, ready=0 (stores: ready=1), advance tail, and increment count unless a commit occurs on the same edge.
REQ-017 SHALL, on a writeback (rs or lsb) matching a busy, not-ready entry, store the value and set ready at that edge; both buses may hit different entries on the same edge.
REQ-018 SHALL make qryN_ready/qryN_value combinational from the stored entry: ready=1 when busy and ready, value = stored value, else 0.
REQ-019 SHALL commit at most one entry per edge: the head entry, when busy and ready, retires; head advances and count decrements.
REQ-020 SHALL register commit outputs: a retiring ALU entry raises commit_valid with rd/value/rob_id for exactly one cycle after the edge; a store raises commit_store; a branch raises neither.
REQ-021 SHALL, when a retiring branch has value[0] != pred, raise clear for one cycle with clear_pc = alt_pc.
REQ-022 SHALL, on that clear edge, invalidate all entries, set head=tail=count=0, and discard same-edge issue and writebacks.
REQ-023 SHALL treat issue and commit on the same edge as net count unchanged; with count==2^ROB_SIZE_BIT and a commit, full deasserts the next cycle.
REQ-024 SHALL, while rdy_in=0, change no state and drive commit_valid, commit_store and clear to 0.

Reset
REQ-025 SHALL, while rst_in=1 at an edge, clear all busy/ready bits, set head=tail=count=0, and drive all registered outputs (commit_*, clear, clear_pc) to 0; rst_in overrides rdy_in and all inputs.
REQ-026 SHALL, on reset mid-operation, lose all in-flight entries without emitting any commit.

Configuration
REQ-027 SHALL support macro ROB_BYPASS_EN. When defined, qryN also returns ready=1 with the bus value if rs or lsb is writing qryN_id in the same cycle (rs has priority). When undefined, the lookup reflects only stored state, with one cycle of extra latency.

Verification
REQ-028 Reset, then issue ALU rd=5 (id 0), rs writeback id 0 value 0x1234 -> commit_valid one cycle later with rd=5, value=0x1234, rob_id=0.
REQ-029 Issue 2^ROB_SIZE_BIT entries with no writeback -> full=1; an extra issue is ignored; write head back -> next cycle commit, full=0, tail wraps to 0.
REQ-030 Issue ids 0,1; write id 1 then id 0 -> commits in order 0 then 1 on consecutive cycles.
REQ-031 Issue branch pred=1, alt_pc=0x100, plus an ALU entry behind it; write branch value 0 -> clear=1, clear_pc=0x100, count=0, and the ALU entry never commits.
REQ-032 Same-cycle rs writeback of id 3 and query qry1_id=3 -> ready=1/value only with ROB_BYPASS_EN; without it, ready=1 next cycle.
REQ-033 rdy_in low for 3 cycles with a ready head -> no commit while low; commit on the first edge after rdy_in returns high.
